// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide memory port bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus RAM/IO environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  rdy_in;
  logic                  rob_flush_in;

  logic                  ifetch_req_in;
  logic [ADDR_WIDTH-1:0] ifetch_addr_in;
  logic                  ifetch_done_out;
  logic [31:0]           ifetch_data_out;

  logic                  lbuffer_req_in;
  logic [ADDR_WIDTH-1:0] lbuffer_addr_in;
  logic [1:0]            lbuffer_size_in;
  logic                  lbuffer_done_out;
  logic [31:0]           lbuffer_data_out;

  logic                  store_req_in;
  logic [ADDR_WIDTH-1:0] store_addr_in;
  logic [1:0]            store_size_in;
  logic [31:0]           store_data_in;
  logic                  store_done_out;

  logic                  io_buffer_full_in;
  logic [7:0]            mem_din_in;
  logic [7:0]            mem_dout_out;
  logic [ADDR_WIDTH-1:0] mem_a_out;
  logic                  mem_wr_out;

  modport slave (
    input  rdy_in, rob_flush_in,
    input  ifetch_req_in, ifetch_addr_in,
    output ifetch_done_out, ifetch_data_out,
    input  lbuffer_req_in, lbuffer_addr_in, lbuffer_size_in,
    output lbuffer_done_out, lbuffer_data_out,
    input  store_req_in, store_addr_in, store_size_in, store_data_in,
    output store_done_out,
    input  io_buffer_full_in, mem_din_in,
    output mem_dout_out, mem_a_out, mem_wr_out
  );

  modport master (
    output rdy_in, rob_flush_in,
    output ifetch_req_in, ifetch_addr_in,
    input  ifetch_done_out, ifetch_data_out,
    output lbuffer_req_in, lbuffer_addr_in, lbuffer_size_in,
    input  lbuffer_done_out, lbuffer_data_out,
    output store_req_in, store_addr_in, store_size_in, store_data_in,
    input  store_done_out,
    output io_buffer_full_in, mem_din_in,
    input  mem_dout_out, mem_a_out, mem_wr_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (store > load > fetch) arbiter serialising 1/2/4-byte transfers onto
// the byte-wide RAM/IO port. Optional macro IO_STALL_EN: stall IO stores while the IO buffer is full.
module mem_arbiter #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(32'h30000)
) (
  input logic          clk_in,
  input logic          rst_in,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ_IF  = 2'd1,
    READ_LB  = 2'd2,
    WRITE_ST = 2'd3
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      nbytes;
  logic [ADDR_WIDTH-1:0] base;
  logic [WORD_W-1:0]     wdata;
  logic [WORD_W-1:0]     rdata;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            wr_byte;
  logic [WORD_W-1:0]     rd_merge;
  logic                  stall_cur;
  logic                  stall_grant;
  logic                  grant_st;
  logic                  grant_lb;
  logic                  grant_if;
  logic [CNT_W-1:0]      st_bytes;
  logic [CNT_W-1:0]      lb_bytes;

  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    logic [CNT_W-1:0] n;
    case (size)
      2'd0:    n = CNT_W'(1);
      2'd1:    n = CNT_W'(2);
      default: n = CNT_W'(4);
    endcase
    return n;
  endfunction

  // Per-cycle address/byte selection and grant qualification.
  always_comb begin
    cur_addr    = base + ADDR_WIDTH'(cnt);
    wr_byte     = wdata[7:0];
    rd_merge    = rdata;
    stall_cur   = 1'b0;
    stall_grant = 1'b0;
    st_bytes    = size_bytes(bus.store_size_in);
    lb_bytes    = size_bytes(bus.lbuffer_size_in);

    case (cnt[1:0])
      2'd1:    wr_byte = wdata[15:8];
      2'd2:    wr_byte = wdata[23:16];
      2'd3:    wr_byte = wdata[31:24];
      default: wr_byte = wdata[7:0];
    endcase

    // Byte k arrives on mem_din_in two edges after its address was driven.
    case (cnt)
      CNT_W'(2): rd_merge[7:0]   = bus.mem_din_in;
      CNT_W'(3): rd_merge[15:8]  = bus.mem_din_in;
      CNT_W'(4): rd_merge[23:16] = bus.mem_din_in;
      CNT_W'(5): rd_merge[31:24] = bus.mem_din_in;
      default:   rd_merge        = rdata;
    endcase

`ifdef IO_STALL_EN
    stall_cur   = (cur_addr >= IO_ADDR_BASE) && bus.io_buffer_full_in;
    stall_grant = (bus.store_addr_in >= IO_ADDR_BASE) && bus.io_buffer_full_in;
`endif

    grant_st = bus.store_req_in && !bus.store_done_out;
    grant_lb = bus.lbuffer_req_in && !bus.lbuffer_done_out && !bus.rob_flush_in;
    grant_if = bus.ifetch_req_in && !bus.ifetch_done_out && !bus.rob_flush_in;
  end

`ifndef IO_STALL_EN
  logic unused_io_full;
  assign unused_io_full = bus.io_buffer_full_in;
`endif

  // Arbitration FSM with all outputs registered; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state                <= IDLE;
      cnt                  <= '0;
      nbytes               <= '0;
      base                 <= '0;
      wdata                <= '0;
      rdata                <= '0;
      bus.ifetch_done_out  <= 1'b0;
      bus.ifetch_data_out  <= '0;
      bus.lbuffer_done_out <= 1'b0;
      bus.lbuffer_data_out <= '0;
      bus.store_done_out   <= 1'b0;
      bus.mem_dout_out     <= '0;
      bus.mem_a_out        <= '0;
      bus.mem_wr_out       <= 1'b0;
    end else if (bus.rdy_in) begin
      bus.ifetch_done_out  <= 1'b0;
      bus.lbuffer_done_out <= 1'b0;
      bus.store_done_out   <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_st) begin
            state  <= WRITE_ST;
            base   <= bus.store_addr_in;
            nbytes <= st_bytes;
            wdata  <= bus.store_data_in;
            if (stall_grant) begin
              cnt            <= '0;
              bus.mem_wr_out <= 1'b0;
            end else begin
              cnt                <= CNT_W'(1);
              bus.mem_a_out      <= bus.store_addr_in;
              bus.mem_dout_out   <= bus.store_data_in[7:0];
              bus.mem_wr_out     <= 1'b1;
              bus.store_done_out <= (st_bytes == CNT_W'(1));
            end
          end else if (grant_lb) begin
            state          <= READ_LB;
            base           <= bus.lbuffer_addr_in;
            nbytes         <= lb_bytes;
            rdata          <= '0;
            cnt            <= CNT_W'(1);
            bus.mem_a_out  <= bus.lbuffer_addr_in;
            bus.mem_wr_out <= 1'b0;
          end else if (grant_if) begin
            state          <= READ_IF;
            base           <= bus.ifetch_addr_in;
            nbytes         <= CNT_W'(4);
            rdata          <= '0;
            cnt            <= CNT_W'(1);
            bus.mem_a_out  <= bus.ifetch_addr_in;
            bus.mem_wr_out <= 1'b0;
          end
        end

        READ_IF, READ_LB: begin
          if (bus.rob_flush_in) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_a_out <= '0;
          end else begin
            rdata <= rd_merge;
            if (cnt == CNT_W'(nbytes + CNT_W'(1))) begin
              state         <= IDLE;
              cnt           <= '0;
              bus.mem_a_out <= '0;
              if (state == READ_IF) begin
                bus.ifetch_done_out <= 1'b1;
                bus.ifetch_data_out <= rd_merge;
              end else begin
                bus.lbuffer_done_out <= 1'b1;
                bus.lbuffer_data_out <= rd_merge;
              end
            end else begin
              cnt           <= cnt + CNT_W'(1);
              bus.mem_a_out <= (cnt < nbytes) ? cur_addr : '0;
            end
          end
        end

        WRITE_ST: begin
          if (cnt == nbytes) begin
            state            <= IDLE;
            cnt              <= '0;
            bus.mem_wr_out   <= 1'b0;
            bus.mem_a_out    <= '0;
            bus.mem_dout_out <= '0;
          end else if (stall_cur) begin
            bus.mem_wr_out <= 1'b0;
          end else begin
            cnt                <= cnt + CNT_W'(1);
            bus.mem_a_out      <= cur_addr;
            bus.mem_dout_out   <= wr_byte;
            bus.mem_wr_out     <= 1'b1;
            bus.store_done_out <= (cnt == CNT_W'(nbytes - CNT_W'(1)));
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency byte RAM model.
// Scenario 5 expectations follow IO_STALL_EN when the bench is built with it.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0] ram [int unsigned];

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .IO_ADDR_BASE(32'h30000)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // Byte RAM: write on wr=1, otherwise read data available the following cycle.
  always @(posedge clk) begin
    if (bus.rdy_in) begin
      if (bus.mem_wr_out) ram[bus.mem_a_out] = bus.mem_dout_out;
      else bus.mem_din_in <= ram.exists(bus.mem_a_out) ? ram[bus.mem_a_out] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_a   [4];
  logic [31:0] exp_d   [4];
  logic [31:0] exp_wd  [4];

  initial begin
    bus.rdy_in = 1'b1;            bus.rob_flush_in = 1'b0;
    bus.ifetch_req_in = 1'b0;     bus.ifetch_addr_in = '0;
    bus.lbuffer_req_in = 1'b0;    bus.lbuffer_addr_in = '0; bus.lbuffer_size_in = 2'd0;
    bus.store_req_in = 1'b0;      bus.store_addr_in = '0;   bus.store_size_in = 2'd0;
    bus.store_data_in = '0;       bus.io_buffer_full_in = 1'b0;
    bus.mem_din_in = 8'h00;
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h20] = 8'hF0;

    tick(); tick();
    check("rst_a",  bus.mem_a_out, 32'h0);
    check("rst_wr", 32'(bus.mem_wr_out), 32'h0);
    check("rst_done", 32'({bus.ifetch_done_out, bus.lbuffer_done_out, bus.store_done_out}), 32'h0);
    rst = 1'b1;
    tick();

    // 1: word fetch, done on the 5th edge after grant
    bus.ifetch_addr_in = 32'h1000; bus.ifetch_req_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_done", 32'(bus.ifetch_done_out), 32'(k == 5));
      if (k < 4) begin
        check("t1_addr", bus.mem_a_out, 32'h1000 + 32'(k));
        check("t1_wr", 32'(bus.mem_wr_out), 32'h0);
      end
    end
    check("t1_data", bus.ifetch_data_out, 32'h00000513);
    bus.ifetch_req_in = 1'b0;
    tick();
    check("t1_pulse", 32'(bus.ifetch_done_out), 32'h0);
    check("t1_hold", bus.ifetch_data_out, 32'h00000513);

    // 2: load byte beats fetch; fetch starts right after load done
    bus.lbuffer_addr_in = 32'h20; bus.lbuffer_size_in = 2'd0; bus.lbuffer_req_in = 1'b1;
    bus.ifetch_req_in = 1'b1;
    tick(); check("t2_a0", bus.mem_a_out, 32'h20);
    tick(); check("t2_done_early", 32'(bus.lbuffer_done_out), 32'h0);
    tick(); check("t2_done", 32'(bus.lbuffer_done_out), 32'h1);
    check("t2_data", bus.lbuffer_data_out, 32'h000000F0);
    check("t2_if_idle", 32'(bus.ifetch_done_out), 32'h0);
    bus.lbuffer_req_in = 1'b0;
    tick(); check("t2_if_grant", bus.mem_a_out, 32'h1000);
    for (int k = 0; k < 5; k++) tick();
    check("t2_if_done", 32'(bus.ifetch_done_out), 32'h1);
    bus.ifetch_req_in = 1'b0;
    tick();

    // 3: store word beats load and fetch
    exp_a[0] = 32'h40; exp_a[1] = 32'h41; exp_a[2] = 32'h42; exp_a[3] = 32'h43;
    exp_d[0] = 32'hEF; exp_d[1] = 32'hBE; exp_d[2] = 32'hAD; exp_d[3] = 32'hDE;
    bus.store_addr_in = 32'h40; bus.store_size_in = 2'd2; bus.store_data_in = 32'hDEADBEEF;
    bus.store_req_in = 1'b1; bus.lbuffer_req_in = 1'b1; bus.ifetch_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3_a", bus.mem_a_out, exp_a[k]);
      check("t3_d", 32'(bus.mem_dout_out), exp_d[k]);
      check("t3_wr", 32'(bus.mem_wr_out), 32'h1);
      check("t3_done", 32'(bus.store_done_out), 32'(k == 3));
    end
    bus.store_req_in = 1'b0;
    tick(); check("t3_wr_end", 32'(bus.mem_wr_out), 32'h0);
    tick(); check("t3_lb_next", bus.mem_a_out, 32'h20);
    tick(); tick(); check("t3_lb_done", 32'(bus.lbuffer_done_out), 32'h1);
    bus.lbuffer_req_in = 1'b0;
    tick(); check("t3_if_next", bus.mem_a_out, 32'h1000);
    for (int k = 0; k < 5; k++) tick();
    check("t3_if_done", 32'(bus.ifetch_done_out), 32'h1);
    bus.ifetch_req_in = 1'b0;
    check("t3_ram", {ram[32'h43], ram[32'h42], ram[32'h41], ram[32'h40]}, 32'hDEADBEEF);
    tick();

    // 4a: flush aborts a word load after two bytes captured
    bus.lbuffer_addr_in = 32'h40; bus.lbuffer_size_in = 2'd2; bus.lbuffer_req_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t4_a3", bus.mem_a_out, 32'h43);
    bus.rob_flush_in = 1'b1;
    tick();
    check("t4_abort_a", bus.mem_a_out, 32'h0);
    bus.rob_flush_in = 1'b0; bus.lbuffer_req_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_no_done", 32'(bus.lbuffer_done_out), 32'h0);
    end
    check("t4_data_hold", bus.lbuffer_data_out, 32'h000000F0);

    // 4b: store half under flush still completes
    bus.store_addr_in = 32'h50; bus.store_size_in = 2'd1; bus.store_data_in = 32'h00001234;
    bus.store_req_in = 1'b1; bus.rob_flush_in = 1'b1;
    tick(); check("t4_st0", {bus.mem_a_out[23:0], bus.mem_dout_out}, 32'h00005034);
    tick(); check("t4_st1", {bus.mem_a_out[23:0], bus.mem_dout_out}, 32'h00005112);
    check("t4_st_done", 32'(bus.store_done_out), 32'h1);
    bus.store_req_in = 1'b0; bus.rob_flush_in = 1'b0;
    tick(); check("t4_st_end", 32'(bus.mem_wr_out), 32'h0);

    // 5: byte store to IO space while IO buffer is full
    bus.store_addr_in = 32'h30000; bus.store_size_in = 2'd0; bus.store_data_in = 32'h41;
    bus.store_req_in = 1'b1; bus.io_buffer_full_in = 1'b1;
`ifdef IO_STALL_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_stall_wr", 32'(bus.mem_wr_out), 32'h0);
      check("t5_stall_done", 32'(bus.store_done_out), 32'h0);
    end
    bus.io_buffer_full_in = 1'b0;
`endif
    tick();
    check("t5_wr", 32'(bus.mem_wr_out), 32'h1);
    check("t5_a", bus.mem_a_out, 32'h30000);
    check("t5_d", 32'(bus.mem_dout_out), 32'h41);
    check("t5_done", 32'(bus.store_done_out), 32'h1);
    bus.store_req_in = 1'b0; bus.io_buffer_full_in = 1'b0;
    tick(); check("t5_end", 32'(bus.mem_wr_out), 32'h0);

    // 6a: reset in the middle of a read clears every output
    bus.lbuffer_addr_in = 32'h1000; bus.lbuffer_size_in = 2'd2; bus.lbuffer_req_in = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_rst_a", bus.mem_a_out, 32'h0);
    check("t6_rst_if", bus.ifetch_data_out, 32'h0);
    check("t6_rst_lb", bus.lbuffer_data_out, 32'h0);
    bus.lbuffer_req_in = 1'b0; rst = 1'b1;
    tick();

    // 6b: rdy low freezes a word write mid-transfer
    exp_wd[0] = 32'h0D; exp_wd[1] = 32'hF0; exp_wd[2] = 32'hFE; exp_wd[3] = 32'hCA;
    bus.store_addr_in = 32'h60; bus.store_size_in = 2'd2; bus.store_data_in = 32'hCAFEF00D;
    bus.store_req_in = 1'b1;
    tick(); tick();
    check("t6_a1", bus.mem_a_out, 32'h61);
    bus.rdy_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t6_frz_a", bus.mem_a_out, 32'h61);
      check("t6_frz_d", 32'(bus.mem_dout_out), exp_wd[1]);
      check("t6_frz_wr", 32'(bus.mem_wr_out), 32'h1);
    end
    bus.rdy_in = 1'b1;
    tick(); check("t6_a2", {bus.mem_a_out[23:0], bus.mem_dout_out}, {24'h62, exp_wd[2][7:0]});
    tick(); check("t6_a3", {bus.mem_a_out[23:0], bus.mem_dout_out}, {24'h63, exp_wd[3][7:0]});
    check("t6_done", 32'(bus.store_done_out), 32'h1);
    bus.store_req_in = 1'b0;
    tick(); check("t6_end", 32'(bus.mem_wr_out), 32'h0);
    check("t6_ram", {ram[32'h63], ram[32'h62], ram[32'h61], ram[32'h60]}, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
